led_sequencer: RTL

Parametrised multi-channel LED pattern generator for the board LED bank. A shared tick divider advances one of several selectable patterns: binary count, walking one, PWM breathing or off. Outputs are registered and polarity-configurable so they drive the board's LED pins directly. It supersedes the fixed 3-LED binary blinker in top-level designs.

---
 rtl/led_seq_pkg.sv | 18 +
 rtl/tick_divider.sv | 36 +++
 rtl/led_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types for the LED sequencer.
//   mode_e - pattern selector as driven on the 2-bit mode input
//   dir_e  - ramp direction of the breathing pattern
package led_seq_pkg;

   typedef enum logic [1:0] {
      MODE_COUNT   = 2'd0,
      MODE_WALK    = 2'd1,
      MODE_BREATHE = 2'd2,
      MODE_OFF     = 2'd3
   } mode_e;

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } dir_e;

endpackage

// File: rtl/tick_divider.sv
// tick_divider: free-running step divider, counts 0..TICK_CYCLES-1 and wraps.
//   clock  - rising-edge clock
//   reset  - synchronous active-high reset, counter to 0
//   clear  - synchronous restart, counter to 0 (same effect as reset)
//   enable - 1 advances the counter, 0 holds it
//   tick   - combinational, high on the terminal count while enable=1
module tick_divider #(
   parameter int unsigned TICK_CYCLES = 12_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int unsigned W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [W-1:0] LAST = W'(TICK_CYCLES - 1);

   logic [W-1:0] count;

   assign tick = enable && (count == LAST);

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         if (count == LAST) begin
            count <= '0;
         end else begin
            count <= count + W'(1);
         end
      end
   end

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: multi-channel LED pattern generator for the board LED bank.
//   clock      - sole clock, rising edge
//   reset      - synchronous active-high reset
//   enable     - 1 advances divider and pattern, 0 freezes them
//   mode       - 0 COUNT, 1 WALK, 2 BREATHE, 3 OFF
//   led        - registered LED pin drive, logical value XOR ACTIVE_LOW
//   step_pulse - one-cycle strobe, high in the cycle led first shows a step
// A change on mode restarts the divider and all pattern registers; the
// restart wins over a step falling on the same cycle.
module led_sequencer
   import led_seq_pkg::*;
#(
   parameter int unsigned TICK_CYCLES = 12_000_000,
   parameter int unsigned NUM_LEDS    = 3,
   parameter int unsigned PWM_BITS    = 8,
   parameter bit          ACTIVE_LOW  = 1'b1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic [1:0]          mode,
   output logic [NUM_LEDS-1:0] led,
   output logic                step_pulse
);

   localparam logic [NUM_LEDS-1:0] WALK_INIT = NUM_LEDS'(1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
   localparam logic [NUM_LEDS-1:0] PIN_OFF   = {NUM_LEDS{ACTIVE_LOW}};

   mode_e               mode_in;
   mode_e               mode_q;
   logic                restart;
   logic                tick;
   logic                step;
   logic                step_q;

   logic [NUM_LEDS-1:0] count_q, count_d;
   logic [NUM_LEDS-1:0] walk_q,  walk_d;
   logic [PWM_BITS-1:0] duty_q,  duty_d;
   dir_e                dir_q,   dir_d;
   logic [PWM_BITS-1:0] pwm_q;
   logic [NUM_LEDS-1:0] logical;

   assign mode_in = mode_e'(mode);
   assign restart = (mode_in != mode_q);
   assign step    = tick && !restart;

   tick_divider #(
      .TICK_CYCLES (TICK_CYCLES)
   ) u_div (
      .clock  (clock),
      .reset  (reset),
      .clear  (restart),
      .enable (enable),
      .tick   (tick)
   );

   // Pattern next-state: restart loads the initial pattern, otherwise the
   // active mode's register advances only on a step.
   always_comb begin
      count_d = count_q;
      walk_d  = walk_q;
      duty_d  = duty_q;
      dir_d   = dir_q;
      if (restart) begin
         count_d = '0;
         walk_d  = WALK_INIT;
         duty_d  = '0;
         dir_d   = UP;
      end else if (step) begin
         case (mode_q)
            MODE_COUNT: count_d = count_q + NUM_LEDS'(1);
            MODE_WALK:  walk_d  = {walk_q[NUM_LEDS-2:0], walk_q[NUM_LEDS-1]};
            MODE_BREATHE: begin
               // At either end of the ramp the duty holds for one step
               // while the direction flips.
               if (dir_q == UP) begin
                  if (duty_q == DUTY_MAX) begin
                     dir_d = DOWN;
                  end else begin
                     duty_d = duty_q + PWM_BITS'(1);
                  end
               end else begin
                  if (duty_q == '0) begin
                     dir_d = UP;
                  end else begin
                     duty_d = duty_q - PWM_BITS'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Logical LED value from the current pattern registers.
   always_comb begin
      logical = '0;
      case (mode_q)
         MODE_COUNT:   logical = count_q;
         MODE_WALK:    logical = walk_q;
         MODE_BREATHE: logical = {NUM_LEDS{pwm_q < duty_q}};
         default:      logical = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mode_q  <= MODE_COUNT;
         count_q <= '0;
         walk_q  <= WALK_INIT;
         duty_q  <= '0;
         dir_q   <= UP;
      end else begin
         mode_q  <= mode_in;
         count_q <= count_d;
         walk_q  <= walk_d;
         duty_q  <= duty_d;
         dir_q   <= dir_d;
      end
   end

   // PWM phase runs regardless of enable so a frozen duty keeps dimming.
   always_ff @(posedge clock) begin
      if (reset) begin
         pwm_q <= '0;
      end else begin
         pwm_q <= pwm_q + PWM_BITS'(1);
      end
   end

   // The pattern updates on the step edge and led one edge later, so the
   // strobe is delayed two stages to line up with the first new led value.
   always_ff @(posedge clock) begin
      if (reset) begin
         step_q     <= 1'b0;
         step_pulse <= 1'b0;
         led        <= PIN_OFF;
      end else begin
         step_q     <= step;
         step_pulse <= step_q;
         led        <= logical ^ PIN_OFF;
      end
   end

endmodule
